// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC/flag sequencer: condition codes, flag bit positions, FSM states.
// No logic here; consumed by pc_flag_sequencer and branch_cond_eval.
// Flag register layout is {N, V, Z} from MSB to LSB.
package pc_seq_pkg;

    localparam logic [2:0] COND_NE     = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GE     = 3'b100;
    localparam logic [2:0] COND_LE     = 3'b101;
    localparam logic [2:0] COND_OV     = 3'b110;
    localparam logic [2:0] COND_ALWAYS = 3'b111;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        BR_WAIT = 2'b01,
        HALTED  = 2'b10
    } seq_state_e;

endpackage

// File: rtl/pc_flag_sequencer_branch_cond_eval.sv
// Resolves a 3-bit branch condition code against the {N,V,Z} flag register.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module branch_cond_eval
    import pc_seq_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic n_f;
    logic v_f;
    logic z_f;

    assign n_f = flags[FLAG_N];
    assign v_f = flags[FLAG_V];
    assign z_f = flags[FLAG_Z];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NE:     taken = ~z_f;
            COND_EQ:     taken = z_f;
            COND_GT:     taken = ~z_f & ~n_f;
            COND_LT:     taken = n_f;
            COND_GE:     taken = z_f | (~z_f & ~n_f);
            COND_LE:     taken = n_f | z_f;
            COND_OV:     taken = v_f;
            COND_ALWAYS: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_flag_sequencer.sv
// PC sequencer: next-PC selection, branch resolution against flags, flush/stall generation, halt.
// Latency: one cycle from decision to pc_out/flush; stall_req asserts the cycle after entering BR_WAIT.
// Backpressure: stall freezes all state; stall_req holds upstream while a branch waits on busy flags.
module pc_flag_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               IMM_W    = 9,
    parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [2:0]       flags,
    input  logic             flags_busy,
    input  logic             br_valid,
    input  logic             br_is_reg,
    input  logic [2:0]       br_cond,
    input  logic [IMM_W-1:0] br_imm,
    input  logic [WIDTH-1:0] br_npc,
    input  logic [WIDTH-1:0] br_reg,
    input  logic             halt_valid,
    output logic [WIDTH-1:0] pc_out,
    output logic             flush,
    output logic             stall_req,
    output logic             halted
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(2);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             flush_q, flush_d;
    logic             stall_req_q, stall_req_d;

    logic             br_taken;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] br_target;

    branch_cond_eval u_cond (
        .cond  (br_cond),
        .flags (flags),
        .taken (br_taken)
    );

    // Immediate counts halfwords; the add wraps silently at 2^WIDTH.
    assign imm_sext  = {{(WIDTH-IMM_W){br_imm[IMM_W-1]}}, br_imm};
    assign br_target = br_is_reg ? br_reg : (br_npc + (imm_sext << 1));

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_d     = 1'b0;
        stall_req_d = 1'b0;
        case (state_q)
            RUN: begin
                if (stall) begin
                    pc_d = pc_q;
                end else if (br_valid) begin
                    if ((br_cond != COND_ALWAYS) && flags_busy) begin
                        state_d     = BR_WAIT;
                        stall_req_d = 1'b1;
                    end else if (br_taken) begin
                        pc_d    = br_target;
                        flush_d = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end else if (halt_valid) begin
                    state_d = HALTED;
                end else begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            BR_WAIT: begin
                if (stall || flags_busy) begin
                    stall_req_d = 1'b1;
                end else begin
                    state_d = RUN;
                    if (br_taken) begin
                        pc_d    = br_target;
                        flush_d = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            flush_q     <= 1'b0;
            stall_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_q     <= flush_d;
            stall_req_q <= stall_req_d;
        end
    end

    assign pc_out    = pc_q;
    assign flush     = flush_q;
    assign stall_req = stall_req_q;
    assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_pc_flag_sequencer.sv
// Directed bench for pc_flag_sequencer with hand-computed expected values.
module tb_pc_flag_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  flags;
    logic        flags_busy;
    logic        br_valid;
    logic        br_is_reg;
    logic [2:0]  br_cond;
    logic [8:0]  br_imm;
    logic [15:0] br_npc;
    logic [15:0] br_reg;
    logic        halt_valid;
    logic [15:0] pc_out;
    logic        flush;
    logic        stall_req;
    logic        halted;

    int n_tests;
    int n_fail;

    pc_flag_sequencer #(
        .WIDTH    (16),
        .IMM_W    (9),
        .RESET_PC (16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flags      (flags),
        .flags_busy (flags_busy),
        .br_valid   (br_valid),
        .br_is_reg  (br_is_reg),
        .br_cond    (br_cond),
        .br_imm     (br_imm),
        .br_npc     (br_npc),
        .br_reg     (br_reg),
        .halt_valid (halt_valid),
        .pc_out     (pc_out),
        .flush      (flush),
        .stall_req  (stall_req),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [15:0] exp_pc, input logic exp_flush,
                             input logic exp_sreq, input logic exp_halt);
        check_eq({tag, ".pc"}, 32'(pc_out), 32'(exp_pc));
        check_eq({tag, ".flush"}, 32'(flush), 32'(exp_flush));
        check_eq({tag, ".stall_req"}, 32'(stall_req), 32'(exp_sreq));
        check_eq({tag, ".halted"}, 32'(halted), 32'(exp_halt));
    endtask

    task automatic set_br(input logic valid, input logic is_reg, input logic [2:0] cond,
                          input logic [8:0] imm, input logic [15:0] npc, input logic [15:0] rg);
        br_valid  = valid;
        br_is_reg = is_reg;
        br_cond   = cond;
        br_imm    = imm;
        br_npc    = npc;
        br_reg    = rg;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        stall      = 1'b0;
        flags      = 3'b000;
        flags_busy = 1'b0;
        halt_valid = 1'b0;
        set_br(1'b0, 1'b0, 3'b000, 9'h000, 16'h0000, 16'h0000);

        step();
        step();
        check_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 1; i <= 4; i++) begin
            step();
            check_out($sformatf("idle%0d", i), 16'(2 * i), 1'b0, 1'b0, 1'b0);
        end

        // B EQ taken: 0x0010 + 3*2
        flags = 3'b001;
        set_br(1'b1, 1'b0, 3'b001, 9'h003, 16'h0010, 16'h0000);
        step();
        check_out("beq_taken", 16'h0016, 1'b1, 1'b0, 1'b0);
        br_valid = 1'b0;
        step();
        check_out("beq_after", 16'h0018, 1'b0, 1'b0, 1'b0);

        flags = 3'b000;
        set_br(1'b1, 1'b0, 3'b001, 9'h003, 16'h0010, 16'h0000);
        step();
        check_out("beq_not_taken", 16'h001A, 1'b0, 1'b0, 1'b0);

        // B GT with imm = -1 from 0x0000 wraps to 0xFFFE
        set_br(1'b1, 1'b0, 3'b010, 9'h1FF, 16'h0000, 16'h0000);
        step();
        check_out("bgt_wrap", 16'hFFFE, 1'b1, 1'b0, 1'b0);
        br_valid = 1'b0;
        step();
        check_out("pc_wrap", 16'h0000, 1'b0, 1'b0, 1'b0);

        flags = 3'b001;
        set_br(1'b1, 1'b1, 3'b111, 9'h000, 16'h0000, 16'h1234);
        step();
        check_out("br_always", 16'h1234, 1'b1, 1'b0, 1'b0);
        br_valid = 1'b0;
        step();
        check_out("br_after", 16'h1236, 1'b0, 1'b0, 1'b0);

        // LT waits on busy flags, target 0x0100 + 8*2
        flags      = 3'b000;
        flags_busy = 1'b1;
        set_br(1'b1, 1'b0, 3'b011, 9'h008, 16'h0100, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("lt_wait%0d", i), 16'h1236, 1'b0, 1'b1, 1'b0);
        end
        flags_busy = 1'b0;
        flags      = 3'b100;
        step();
        check_out("lt_release", 16'h0110, 1'b1, 1'b0, 1'b0);
        br_valid = 1'b0;
        step();
        check_out("lt_after", 16'h0112, 1'b0, 1'b0, 1'b0);

        // Unconditional branch ignores flags_busy
        flags_busy = 1'b1;
        set_br(1'b1, 1'b0, 3'b111, 9'h010, 16'h0200, 16'h0000);
        step();
        check_out("always_busy", 16'h0220, 1'b1, 1'b0, 1'b0);
        br_valid   = 1'b0;
        flags_busy = 1'b0;
        step();
        check_out("always_after", 16'h0222, 1'b0, 1'b0, 1'b0);

        // External stall blocks a taken branch
        stall = 1'b1;
        flags = 3'b001;
        set_br(1'b1, 1'b0, 3'b001, 9'h000, 16'h0300, 16'h0000);
        step();
        check_out("stall_hold", 16'h0222, 1'b0, 1'b0, 1'b0);
        stall    = 1'b0;
        br_valid = 1'b0;

        // Branch beats simultaneous halt
        halt_valid = 1'b1;
        set_br(1'b1, 1'b1, 3'b111, 9'h000, 16'h0000, 16'h0018);
        step();
        check_out("br_vs_halt", 16'h0018, 1'b1, 1'b0, 1'b0);
        halt_valid = 1'b0;
        br_valid   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check_out($sformatf("to20_%0d", i), 16'(16'h0018 + 2 * i), 1'b0, 1'b0, 1'b0);
        end

        halt_valid = 1'b1;
        step();
        check_out("halt_enter", 16'h0020, 1'b0, 1'b0, 1'b1);
        halt_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_br(i[0], 1'b1, 3'b111, 9'h000, 16'h0000, 16'h5555);
            flags_busy = i[1];
            step();
            check_out($sformatf("halted%0d", i), 16'h0020, 1'b0, 1'b0, 1'b1);
        end
        br_valid   = 1'b0;
        flags_busy = 1'b0;

        rst = 1'b1;
        step();
        check_out("rst_from_halt", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_out("run_after_rst", 16'h0002, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a flag wait
        flags_busy = 1'b1;
        set_br(1'b1, 1'b0, 3'b000, 9'h004, 16'h0040, 16'h0000);
        step();
        check_out("wait_pre_rst", 16'h0002, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        check_out("rst_from_wait", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst        = 1'b0;
        br_valid   = 1'b0;
        flags_busy = 1'b0;
        step();
        check_out("run_after_rst2", 16'h0002, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
